// File: rtl/trap_csr_sequencer_pkg.sv
// Shared CSR addresses, op encoding and trap-sequencer state type.
package csr_pkg;

  localparam logic [11:0] CsrMie      = 12'h304;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;

  typedef enum logic [2:0] {
    OpNone  = 3'b000,
    OpWrite = 3'b001,
    OpSet   = 3'b010,
    OpClear = 3'b011
  } csr_op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSave    = 3'd1,
    StJump    = 3'd2,
    StHandler = 3'd3,
    StRet     = 3'd4
  } trap_state_e;

endpackage

// File: rtl/trap_csr_sequencer_csr_file.sv
// Machine-mode CSR storage: read mux, write/set/clear decode and the trap-save
// hardware update port, which takes priority over software for mepc/mcause.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            hw_we,
  input  logic [XLEN-1:0] hw_mepc,
  input  logic [XLEN-1:0] hw_mcause,
  output logic [XLEN-1:0] mie,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  localparam logic [XLEN-1:0] AlignMask = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0] new_val;
  csr_op_e         op;

  always_comb begin
    case (csr_op)
      3'b001:  op = OpWrite;
      3'b010:  op = OpSet;
      3'b011:  op = OpClear;
      default: op = OpNone;
    endcase
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CsrMie:      csr_rdata = mie_q;
      CsrMtvec:    csr_rdata = mtvec_q;
      CsrMscratch: csr_rdata = mscratch_q;
      CsrMepc:     csr_rdata = mepc_q;
      CsrMcause:   csr_rdata = mcause_q;
      default:     csr_rdata = '0;
    endcase
  end

  // Set/clear operate on the current (old) register value.
  always_comb begin
    case (op)
      OpWrite: new_val = csr_wdata;
      OpSet:   new_val = csr_rdata | csr_wdata;
      OpClear: new_val = csr_rdata & ~csr_wdata;
      default: new_val = csr_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC & AlignMask;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      if (op != OpNone) begin
        case (csr_addr)
          CsrMie:      mie_q      <= new_val;
          CsrMtvec:    mtvec_q    <= new_val & AlignMask;
          CsrMscratch: mscratch_q <= new_val;
          CsrMepc:     mepc_q     <= new_val & AlignMask;
          CsrMcause:   mcause_q   <= new_val;
          default:     ;
        endcase
      end
      // Later assignment overrides a same-cycle software write.
      if (hw_we) begin
        mepc_q   <= hw_mepc & AlignMask;
        mcause_q <= hw_mcause;
      end
    end
  end

  assign mie   = mie_q;
  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule

// File: rtl/trap_csr_sequencer.sv
// Trap sequencer: saves PC/cause on INT_, redirects to mtvec, returns to mepc on
// mret and pulses INT_RST so the interrupt controller retires its request.
module trap_csr_sequencer
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] pc_i,
  input  logic            mret_i,
  input  logic            int_i,
  input  logic [XLEN-1:0] mcause_i,
  output logic [XLEN-1:0] mie_o,
  output logic            int_rst_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_e     state_q;
  logic            stall_q, redirect_q, int_rst_q;
  logic [XLEN-1:0] mtvec, mepc;

  csr_file #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr_file (
    .clk       (clk),
    .rst       (rst),
    .csr_op    (csr_op),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .hw_we     (state_q == StSave),
    .hw_mepc   (pc_i),
    .hw_mcause (mcause_i),
    .mie       (mie_o),
    .mtvec     (mtvec),
    .mepc      (mepc)
  );

  // Strobes are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
      int_rst_q  <= 1'b0;
    end else begin
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
      int_rst_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (int_i) begin
            state_q <= StSave;
            stall_q <= 1'b1;
          end else if (mret_i) begin
            state_q    <= StRet;
            redirect_q <= 1'b1;
          end
        end
        StSave: begin
          state_q    <= StJump;
          stall_q    <= 1'b1;
          redirect_q <= 1'b1;
        end
        StJump: state_q <= StHandler;
        StHandler: begin
          // int_i is ignored here: no nested traps.
          if (mret_i) begin
            state_q    <= StRet;
            redirect_q <= 1'b1;
            int_rst_q  <= 1'b1;
          end
        end
        StRet:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o     = stall_q;
  // Suppress pulses already in flight when reset lands.
  assign redirect_o  = redirect_q & ~rst;
  assign int_rst_o   = int_rst_q & ~rst;
  assign redirect_pc = (state_q == StJump) ? mtvec : mepc;

endmodule

// File: tb/tb_trap_csr_sequencer.sv
// Directed plus randomized bench for trap_csr_sequencer against a cycle-level
// behavioural model of the CSR file and trap sequence.
module tb_trap_csr_sequencer;
  import csr_pkg::*;

  localparam logic [31:0] RstMtvec = 32'h0000_1003;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, pc_i, mcause_i, mie_o, redirect_pc;
  logic        mret_i, int_i, int_rst_o, stall_o, redirect_o;

  always #5 clk = ~clk;

  trap_csr_sequencer #(
    .XLEN        (32),
    .RESET_MTVEC (RstMtvec)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .pc_i        (pc_i),
    .mret_i      (mret_i),
    .int_i       (int_i),
    .mcause_i    (mcause_i),
    .mie_o       (mie_o),
    .int_rst_o   (int_rst_o),
    .stall_o     (stall_o),
    .redirect_o  (redirect_o),
    .redirect_pc (redirect_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: CSR values plus where we are in the trap sequence
  // (0 idle, 1 saving, 2 jumping, 3 in handler, 4 returning).
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  int          m_phase;
  bit          m_from_h;
  bit          m_valid = 1'b0;

  logic [11:0] addrs [7] = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h300, 12'h7ff};

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] apply_op(input logic [31:0] old, input logic [2:0] op,
                                           input logic [31:0] wd);
    case (op)
      3'd1:    return wd;
      3'd2:    return old | wd;
      3'd3:    return old & ~wd;
      default: return old;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check current outputs against the model, advance the model, then clock.
  task automatic cycle();
    logic        exp_redir;
    logic [31:0] nv;
    #1;
    if (m_valid) begin
      exp_redir = (m_phase == 2 || m_phase == 4) && !rst;
      check_bit("stall", stall_o, m_phase == 1 || m_phase == 2);
      check_bit("redirect", redirect_o, exp_redir);
      if (exp_redir) check("redirect_pc", redirect_pc, (m_phase == 2) ? m_mtvec : m_mepc);
      check_bit("int_rst", int_rst_o, m_phase == 4 && m_from_h && !rst);
      check("mie_o", mie_o, m_mie);
      check("rdata", csr_rdata, m_read(csr_addr));
    end
    if (rst) begin
      m_mie = 0; m_mtvec = RstMtvec & ~32'h3; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_phase = 0; m_from_h = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      nv = apply_op(m_read(csr_addr), csr_op, csr_wdata);
      case (csr_addr)
        12'h304: m_mie      = nv;
        12'h305: m_mtvec    = nv & ~32'h3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        default: ;
      endcase
      if (m_phase == 1) begin
        m_mepc = pc_i & ~32'h3;
        m_mcause = mcause_i;
      end
      case (m_phase)
        0: if (int_i) m_phase = 1; else if (mret_i) begin m_phase = 4; m_from_h = 0; end
        1: m_phase = 2;
        2: m_phase = 3;
        3: if (mret_i) begin m_phase = 4; m_from_h = 1; end
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                       input logic intr, input logic mret);
    csr_op = op; csr_addr = a; csr_wdata = wd; int_i = intr; mret_i = mret;
    cycle();
  endtask

  initial begin
    rst = 1'b1; csr_op = 0; csr_addr = 0; csr_wdata = 0; pc_i = 0; mcause_i = 0;
    int_i = 0; mret_i = 0;
    #1;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state
    check("rst_mie_o", mie_o, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    check_bit("rst_stall", stall_o, 1'b0);
    check_bit("rst_redirect", redirect_o, 1'b0);
    csr_addr = CsrMtvec;
    #1;
    check("rst_mtvec", csr_rdata, 32'h0000_1000);

    // CSR ops
    drive(3'd1, CsrMie, 32'h0000_0808, 0, 0);
    drive(3'd2, CsrMie, 32'h1, 0, 0);
    drive(3'd3, CsrMie, 32'h8, 0, 0);
    check("mie_ops", csr_rdata, 32'h0000_0801);
    drive(3'd1, CsrMtvec, 32'h103, 0, 0);
    check("mtvec_align", csr_rdata, 32'h100);
    drive(3'd1, CsrMscratch, 32'hdead_beef, 0, 0);
    drive(3'd1, 12'h7ff, 32'h1234, 0, 0);
    check("unmapped_read", csr_rdata, 32'h0);

    // Trap entry; controller holds int_i until INT_RST
    pc_i = 32'h200; mcause_i = 32'h3;
    drive(3'd0, CsrMepc, 0, 1, 0);
    check_bit("save_stall", stall_o, 1'b1);
    check_bit("save_noredir", redirect_o, 1'b0);
    drive(3'd0, CsrMepc, 0, 1, 0);
    check_bit("jump_stall", stall_o, 1'b1);
    check_bit("jump_redir", redirect_o, 1'b1);
    check("jump_pc", redirect_pc, 32'h100);
    check("saved_mepc", csr_rdata, 32'h200);
    drive(3'd0, CsrMcause, 0, 1, 0);
    check_bit("hdl_stall", stall_o, 1'b0);
    check("saved_mcause", csr_rdata, 32'h3);
    drive(3'd1, CsrMie, 32'h0, 1, 0);
    check("hdl_mie0", mie_o, 32'h0);
    check("hdl_stays", 32'(dut.state_q), 32'(StHandler));

    // Return
    drive(3'd0, CsrMepc, 0, 1, 1);
    check_bit("ret_redir", redirect_o, 1'b1);
    check("ret_pc", redirect_pc, 32'h200);
    check_bit("ret_intrst", int_rst_o, 1'b1);
    drive(3'd0, CsrMepc, 0, 0, 0);
    check_bit("post_ret_intrst", int_rst_o, 1'b0);
    check("post_ret_state", 32'(dut.state_q), 32'(StIdle));

    // Hardware save beats a same-cycle mepc write
    pc_i = 32'h300; mcause_i = 32'h7;
    drive(3'd0, 12'h0, 0, 1, 0);
    drive(3'd1, CsrMepc, 32'h500, 1, 0);
    check("save_wins", csr_rdata, 32'h300);
    drive(3'd0, 12'h0, 0, 1, 0);
    drive(3'd0, 12'h0, 0, 1, 1);
    drive(3'd0, 12'h0, 0, 0, 0);

    // int_i and mret_i together in IDLE: trap wins
    pc_i = 32'h400;
    drive(3'd0, 12'h0, 0, 1, 1);
    check_bit("both_stall", stall_o, 1'b1);
    check_bit("both_noret", redirect_o, 1'b0);
    drive(3'd0, 12'h0, 0, 0, 0);
    check("both_jump_pc", redirect_pc, 32'h100);

    // Reset while in JUMP
    rst = 1'b1;
    #1;
    check_bit("jrst_noredir", redirect_o, 1'b0);
    cycle();
    rst = 1'b0;
    check("jrst_state", 32'(dut.state_q), 32'(StIdle));
    check("jrst_mie", mie_o, 32'h0);
    csr_addr = CsrMscratch;
    #1;
    check("jrst_mscratch", csr_rdata, 32'h0);
    drive(3'd0, CsrMepc, 0, 0, 0);
    check("jrst_mepc", csr_rdata, 32'h0);
    drive(3'd0, CsrMtvec, 0, 0, 0);
    check("jrst_mtvec", csr_rdata, 32'h1000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      csr_op    = 3'($urandom_range(0, 7));
      csr_addr  = addrs[$urandom_range(0, 6)];
      csr_wdata = $urandom;
      pc_i      = $urandom;
      mcause_i  = $urandom;
      int_i     = ($urandom_range(0, 7) == 0);
      mret_i    = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
